// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: instruction-memory request/response, execute-stage
// redirect, and the fetched-word valid/ready handshake towards decode.
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_fault;

    modport master (
        output imem_addr, inst_out, pc_out, inst_valid, fetch_fault,
        input  imem_instruction, branch_taken, branch_target, inst_ready
    );

    modport slave (
        input  imem_addr, inst_out, pc_out, inst_valid, fetch_fault,
        output imem_instruction, branch_taken, branch_target, inst_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: fixed-latency instruction memory requester with branch redirect.
// Optional MISALIGN_TRAP_EN: misaligned redirect raises fetch_fault and halts until reset.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    instruction_fetch_if.master bus
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {WAIT, HOLD, HALT} state_t;
`else
    typedef enum logic [1:0] {WAIT, HOLD} state_t;
`endif

    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
`ifdef MISALIGN_TRAP_EN
    logic        fault;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= WAIT;
            cnt   <= '0;
            addr  <= RESET_PC;
            inst  <= '0;
            pc    <= '0;
            valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fault <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            // HALT and the fault trap sit ahead of the normal redirect in one priority chain
            if (state == HALT) begin
                valid <= 1'b0;
            end else if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
                fault <= 1'b1;
                valid <= 1'b0;
                state <= HALT;
            end else
`endif
            if (bus.branch_taken) begin
                addr  <= bus.branch_target & 32'hFFFF_FFFC;
                cnt   <= '0;
                valid <= 1'b0;
                state <= WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == LAST) begin
                            inst  <= bus.imem_instruction;
                            pc    <= addr;
                            valid <= 1'b1;
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.inst_ready) begin
                            valid <= 1'b0;
                            cnt   <= '0;
                            addr  <= addr + 32'd4;
                            state <= WAIT;
                        end
                    end
                    default: state <= WAIT;
                endcase
            end
        end
    end

    assign bus.imem_addr  = addr;
    assign bus.inst_out   = inst;
    assign bus.pc_out     = pc;
    assign bus.inst_valid = valid;
`ifdef MISALIGN_TRAP_EN
    assign bus.fetch_fault = fault;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: delayed instruction memory, transaction-level
// reference (next address, age since address change, consumed-word log).
module tb_instruction_fetch;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int unsigned LAT = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(RPC), .MEM_LATENCY(LAT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0109_8020;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    // One register stage on the address gives data two edges after the address changes
    logic [31:0] mem_stage;
    always @(posedge clock) mem_stage <= bus.imem_addr;
    assign bus.imem_instruction = mem_word(mem_stage);

    logic [31:0] m_addr;
    int unsigned m_age;
    logic        m_valid;
    logic        m_halt;
    logic [31:0] hs_log[$];
    int          checks = 0;
    int          errors = 0;

    task automatic model_reset();
        m_addr  = RPC;
        m_age   = 0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // advance one edge; the model uses the inputs present at that edge
    task automatic tick();
        @(posedge clock);
        if (!m_halt) begin
            if (bus.branch_taken) begin
                if (m_valid && bus.inst_ready) hs_log.push_back(m_addr);
                if (TRAP && bus.branch_target[1:0] != 2'b00) begin
                    m_halt  = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_addr  = bus.branch_target & 32'hFFFF_FFFC;
                    m_age   = 0;
                    m_valid = 1'b0;
                end
            end else if (m_valid && bus.inst_ready) begin
                hs_log.push_back(m_addr);
                m_addr  = m_addr + 32'd4;
                m_age   = 0;
                m_valid = 1'b0;
            end else if (!m_valid) begin
                m_age++;
                if (m_age == LAT) m_valid = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0100;
        bus.inst_ready    = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.imem_addr !== RPC) begin errors++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, RPC); end
        checks++;
        if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.inst_valid); end
        checks++;
        if (bus.pc_out !== 32'h0 || bus.inst_out !== 32'h0) begin
            errors++; $display("FAIL reset_data got pc %h inst %h want 0 0", bus.pc_out, bus.inst_out);
        end
        checks++;
        if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.fetch_fault); end
    endtask

    task automatic test_first_fetch();
        apply_reset();
        bus.inst_ready = 1'b1;
        tick();
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_edge1 got valid %b addr %h want 0 0", bus.inst_valid, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_out !== 32'h0109_8020 || bus.pc_out !== 32'h0) begin
            errors++; $display("FAIL first_word got valid %b inst %h pc %h want 1 01098020 0", bus.inst_valid, bus.inst_out, bus.pc_out);
        end
        tick();
        checks++;
        if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL first_next got %h want 4", bus.imem_addr); end
    endtask

    task automatic test_stream();
        int unsigned cyc[$];
        logic [31:0] pcs[$];
        apply_reset();
        bus.inst_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== m_addr || bus.inst_valid !== m_valid ||
                (m_valid && (bus.pc_out !== m_addr || bus.inst_out !== mem_word(m_addr)))) begin
                errors++;
                $display("FAIL stream_cyc%0d got addr %h valid %b pc %h want addr %h valid %b pc %h", i, bus.imem_addr, bus.inst_valid, bus.pc_out, m_addr, m_valid, m_addr);
            end
            if (bus.inst_valid === 1'b1) begin
                cyc.push_back(i);
                pcs.push_back(bus.pc_out);
            end
        end
        checks++;
        if (pcs.size() != 3) begin
            errors++; $display("FAIL stream_count got %0d want 3", pcs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (pcs[k] !== 32'(4 * k) || cyc[k] != 32'(2 + 3 * k)) begin
                    errors++; $display("FAIL stream_word%0d got pc %h cyc %0d want pc %h cyc %0d", k, pcs[k], cyc[k], 4 * k, 2 + 3 * k);
                end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        bus.inst_ready = 1'b1;
        repeat (3) tick();
        bus.inst_ready = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.pc_out !== 32'h4 || bus.inst_out !== mem_word(32'h4) || bus.imem_addr !== 32'h4) begin
                errors++;
                $display("FAIL stall_hold%0d got valid %b pc %h inst %h addr %h want 1 4 %h 4", i, bus.inst_valid, bus.pc_out, bus.inst_out, bus.imem_addr, mem_word(32'h4));
            end
        end
        bus.inst_ready = 1'b1;
        tick();
        checks++;
        if (bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release got addr %h valid %b want 8 0", bus.imem_addr, bus.inst_valid);
        end
    endtask

    task automatic test_redirect_wait();
        bit seen8 = 1'b0;
        bit got = 1'b0;
        tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0014;
        tick();
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            checks++;
            if (bus.imem_addr !== m_addr || bus.inst_valid !== m_valid) begin
                errors++; $display("FAIL redir_wait_cyc%0d got addr %h valid %b want %h %b", i, bus.imem_addr, bus.inst_valid, m_addr, m_valid);
            end
            if (bus.inst_valid === 1'b1) begin
                got = 1'b1;
                if (bus.pc_out === 32'h8) seen8 = 1'b1;
                checks++;
                if (bus.pc_out !== 32'h14 || bus.inst_out !== mem_word(32'h14)) begin
                    errors++; $display("FAIL redir_wait_word got pc %h inst %h want 14 %h", bus.pc_out, bus.inst_out, mem_word(32'h14));
                end
            end
        end
        checks++;
        if (!got || seen8) begin errors++; $display("FAIL redir_wait_timeout got valid %b dropped8 %b want 1 1", got, !seen8); end
    endtask

    task automatic test_redirect_handshake();
        bit got = 1'b0;
        int n4 = 0;
        apply_reset();
        hs_log.delete();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 12 && !(bus.inst_valid === 1'b1 && bus.pc_out === 32'h4); i++) tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0;
        tick();
        bus.branch_taken = 1'b0;
        foreach (hs_log[k]) if (hs_log[k] == 32'h4) n4++;
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 || n4 != 1) begin
            errors++; $display("FAIL redir_hs got addr %h valid %b consumed4 %0d want 0 0 1", bus.imem_addr, bus.inst_valid, n4);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.inst_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus.pc_out !== 32'h0) begin errors++; $display("FAIL redir_hs_next got valid %b pc %h want 1 0", got, bus.pc_out); end
    endtask

    task automatic test_wrap();
        bit got = 1'b0;
        bus.inst_ready    = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        tick();
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.inst_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || bus.pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_word got valid %b pc %h want 1 fffffffc", got, bus.pc_out); end
        bus.inst_ready = 1'b1;
        tick();
        checks++;
        if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_misalign();
        bit got = 1'b0;
        apply_reset();
        bus.inst_ready    = 1'b1;
        tick();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0006;
        tick();
        bus.branch_taken = 1'b0;
        if (TRAP) begin
            for (int i = 0; i < 10; i++) begin
                bus.branch_taken  = 1'($urandom_range(0, 1));
                bus.branch_target = $urandom & 32'hFFFF_FFFC;
                bus.inst_ready    = 1'($urandom_range(0, 1));
                tick();
                checks++;
                if (bus.fetch_fault !== 1'b1 || bus.inst_valid !== 1'b0) begin
                    errors++; $display("FAIL misalign_halt%0d got fault %b valid %b want 1 0", i, bus.fetch_fault, bus.inst_valid);
                end
            end
            bus.branch_taken = 1'b0;
            apply_reset();
            #1;
            checks++;
            if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b want 0", bus.fetch_fault); end
        end else begin
            for (int i = 0; i < 10 && !got; i++) begin
                tick();
                if (bus.inst_valid === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got || bus.pc_out !== 32'h4 || bus.fetch_fault !== 1'b0) begin
                errors++; $display("FAIL misalign_mask got valid %b pc %h fault %b want 1 4 0", got, bus.pc_out, bus.fetch_fault);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            bus.branch_taken  = ($urandom_range(0, 7) == 0);
            bus.branch_target = TRAP ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            bus.inst_ready    = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.imem_addr !== m_addr || bus.inst_valid !== m_valid || bus.fetch_fault !== m_halt ||
                (m_valid && (bus.pc_out !== m_addr || bus.inst_out !== mem_word(m_addr)))) begin
                errors++;
                $display("FAIL random_cyc%0d got addr %h valid %b pc %h inst %h want addr %h valid %b pc %h inst %h", i, bus.imem_addr, bus.inst_valid, bus.pc_out, bus.inst_out, m_addr, m_valid, m_addr, mem_word(m_addr));
            end
        end
        bus.branch_taken = 1'b0;
    endtask

    initial begin
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.inst_ready    = 1'b1;
        apply_reset();
        test_reset();
        test_first_fetch();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_wrap();
        test_misalign();
        test_random();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
